// File: rtl/reg_writeback.sv
// reg_writeback
//   Drives the single write port of the RV32I register file. Single-cycle ALU
//   results and out-of-order load returns are merged onto that port. Load
//   returns are held in a small FIFO. A 32-bit pending-load scoreboard is
//   kept for the issue stage's RAW/WAW stall decisions.
//
//   Optional feature: define WB_BYPASS_EN to enable the write-port bypass on
//   fwd1_* / fwd2_*. When it is not defined, those outputs are tied to 0.
//
// Ports
//   clock, resetn                  clock (rising edge), sync active-low reset
//   alu_valid/alu_rd/alu_data      ALU result in; alu_ready = accepted
//   ld_issue/ld_issue_rd           load issued, mark destination pending
//   ld_valid/ld_rd/ld_data         load data return; ld_ready = accepted
//   chk_rs1/chk_rs2/chk_rd         issue-stage registers to check
//   rs1_busy/rs2_busy/rd_busy      scoreboard lookups for those registers
//   reg_wr_en/write_reg1/write_data registered register-file write port
//   fwd1_*/fwd2_*                  bypass of the in-flight write (optional)
module reg_writeback #(
    parameter int LD_FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_rd,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    input  logic [4:0]  chk_rd,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rd_busy,
    output logic        reg_wr_en,
    output logic [4:0]  write_reg1,
    output logic [31:0] write_data,
    output logic        fwd1_valid,
    output logic [31:0] fwd1_data,
    output logic        fwd2_valid,
    output logic [31:0] fwd2_data
);

    localparam int PTR_W = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       fifo_rd_q   [LD_FIFO_DEPTH];
    logic [31:0]      fifo_data_q [LD_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      sb_q, sb_d;
    logic             reg_wr_en_q, reg_wr_en_d;
    logic [4:0]       write_reg1_q, write_reg1_d;
    logic [31:0]      write_data_q, write_data_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [4:0]       head_rd;
    logic [31:0]      head_data;

    assign fifo_full  = (count_q == CNT_W'(LD_FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head_rd    = fifo_rd_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];

    // A full FIFO also stalls the ALU so that the drain pop is guaranteed
    // the write port on that cycle.
    assign ld_ready  = resetn & ~fifo_full;
    assign alu_ready = resetn & ~fifo_full;
    assign push      = ld_valid & ld_ready;

    always_comb begin
        pop          = 1'b0;
        reg_wr_en_d  = 1'b0;
        write_reg1_d = write_reg1_q;
        write_data_d = write_data_q;
        sb_d         = sb_q;

        // Write-port arbitration: full drain > ALU > opportunistic drain.
        // Entries pushed this cycle are not counted yet, so a head is never
        // popped in its own push cycle.
        if (fifo_full) begin
            pop = 1'b1;
        end else if (alu_valid) begin
            reg_wr_en_d  = (alu_rd != 5'd0);
            write_reg1_d = alu_rd;
            write_data_d = alu_data;
        end else if (!fifo_empty) begin
            pop = 1'b1;
        end

        if (pop) begin
            reg_wr_en_d  = (head_rd != 5'd0);
            write_reg1_d = head_rd;
            write_data_d = head_data;
            sb_d[head_rd] = 1'b0;
        end

        // Applied after the clear so that a same-cycle re-issue keeps the bit.
        if (ld_issue && ld_issue_rd != 5'd0) begin
            sb_d[ld_issue_rd] = 1'b1;
        end
        sb_d[0] = 1'b0;

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            sb_q         <= '0;
            reg_wr_en_q  <= 1'b0;
            write_reg1_q <= '0;
            write_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            sb_q         <= sb_d;
            reg_wr_en_q  <= reg_wr_en_d;
            write_reg1_q <= write_reg1_d;
            write_data_q <= write_data_d;
        end
    end

    // Storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= ld_rd;
            fifo_data_q[wr_ptr_q] <= ld_data;
        end
    end

    assign reg_wr_en  = reg_wr_en_q;
    assign write_reg1 = write_reg1_q;
    assign write_data = write_data_q;

    // sb_q[0] is held at 0, so an x0 lookup always reads not-busy.
    assign rs1_busy = sb_q[chk_rs1];
    assign rs2_busy = sb_q[chk_rs2];
    assign rd_busy  = sb_q[chk_rd];

`ifdef WB_BYPASS_EN
    // The register file commits at the edge that ends the reg_wr_en cycle.
    // A same-cycle read therefore sees the old value, so forward the new one.
    assign fwd1_valid = reg_wr_en_q && (write_reg1_q == chk_rs1) && (chk_rs1 != 5'd0);
    assign fwd1_data  = write_data_q;
    assign fwd2_valid = reg_wr_en_q && (write_reg1_q == chk_rs2) && (chk_rs2 != 5'd0);
    assign fwd2_data  = write_data_q;
`else
    assign fwd1_valid = 1'b0;
    assign fwd1_data  = '0;
    assign fwd2_valid = 1'b0;
    assign fwd2_data  = '0;
`endif

endmodule
